// File: rtl/led_pattern_gen.sv
// LED display engine: binary count, Gray count, bounce scan and PWM breathe
// patterns, stepped by a free-running prescaler and cycled by a mode button.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 22,
  parameter int PWM_BITS = 4
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             mode_next,
  input  logic             dir,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int POS_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PRESCALE-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                scan_up_q, scan_up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_up_q, duty_up_d;
  mode_e               mode_q, mode_d;
  logic                mode_next_q, mode_next_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic                tick_q, tick_d;

  logic mode_edge;
  logic step;

  always_comb begin
    mode_edge   = mode_next & ~mode_next_q;
    step        = run & (psc_q == '1) & ~clear;

    mode_next_d = mode_next;
    tick_d      = step;
    mode_d      = mode_q;
    psc_d       = run ? psc_q + PRESCALE'(1) : psc_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    scan_up_d   = scan_up_q;
    duty_d      = duty_q;
    duty_up_d   = duty_up_q;

    if (mode_edge) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end

    // Clear and mode changes both restart every pattern; a step landing on them is dropped.
    if (clear || mode_edge) begin
      psc_d     = '0;
      cnt_d     = '0;
      pos_d     = '0;
      scan_up_d = 1'b1;
      duty_d    = '0;
      duty_up_d = 1'b1;
    end else if (step) begin
      case (mode_q)
        MODE_BINARY, MODE_GRAY: begin
          cnt_d = dir ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
        end
        MODE_SCAN: begin
          if (scan_up_q) begin
            if (pos_q == POS_W'(WIDTH - 1)) begin
              scan_up_d = 1'b0;
              pos_d     = POS_W'(WIDTH - 2);
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              scan_up_d = 1'b1;
              pos_d     = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        MODE_BREATHE: begin
          if (duty_up_q) begin
            if (duty_q == '1) begin
              duty_up_d = 1'b0;
              duty_d    = duty_q - PWM_BITS'(1);
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_up_d = 1'b1;
              duty_d    = PWM_BITS'(1);
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // The LED image is rendered from the current state, so it trails the state by a cycle.
    case (mode_q)
      MODE_BINARY:  led_d = cnt_q;
      MODE_GRAY:    led_d = cnt_q ^ (cnt_q >> 1);
      MODE_SCAN:    led_d = WIDTH'(1) << pos_q;
      MODE_BREATHE: led_d = (psc_q[PWM_BITS-1:0] < duty_q) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      psc_q       <= '0;
      cnt_q       <= '0;
      pos_q       <= '0;
      scan_up_q   <= 1'b1;
      duty_q      <= '0;
      duty_up_q   <= 1'b1;
      mode_q      <= MODE_BINARY;
      mode_next_q <= 1'b0;
      led_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      psc_q       <= psc_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      scan_up_q   <= scan_up_d;
      duty_q      <= duty_d;
      duty_up_q   <= duty_up_d;
      mode_q      <= mode_d;
      mode_next_q <= mode_next_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a fast-prescaler instance for the count
// and scan modes, and a second instance for breathe-mode duty measurement.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst, run, clear, modeNext, dir;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  logic       rstB, runB, clearB, modeNextB, dirB;
  logic [7:0] ledB;
  logic [1:0] modeB;
  logic       tickB;

  int checks = 0;
  int passes = 0;

  led_pattern_gen #(.WIDTH(8), .PRESCALE(2), .PWM_BITS(1)) dut (
    .clk_25mhz(clk), .rst(rst), .run(run), .clear(clear),
    .mode_next(modeNext), .dir(dir), .led(led), .mode(mode), .tick(tick)
  );

  led_pattern_gen #(.WIDTH(8), .PRESCALE(5), .PWM_BITS(4)) dutB (
    .clk_25mhz(clk), .rst(rstB), .run(runB), .clear(clearB),
    .mode_next(modeNextB), .dir(dirB), .led(ledB), .mode(modeB), .tick(tickB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic m, input logic d);
    run = r; clear = c; modeNext = m; dir = d;
    stepClock();
  endtask

  // Runs until n steps have happened, then freezes and lets led catch up.
  task automatic waitTicks(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 8 + 16) begin
      applyStimulus(1'b1, clear, 1'b0, dir);
      cyc++;
      if (tick) seen++;
    end
    checkOutput("ticks_seen", seen, n);
    applyStimulus(1'b0, clear, 1'b0, dir);
  endtask

  task automatic pulseMode();
    applyStimulus(1'b0, 1'b0, 1'b1, dir);
    applyStimulus(1'b0, 1'b0, 1'b0, dir);
  endtask

  task automatic pulseModeB();
    modeNextB = 1'b1;
    stepClock();
    modeNextB = 1'b0;
    stepClock();
  endtask

  logic [7:0] scanExp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    int ticks;
    int idleTicks;
    int lit;
    int seenB;
    int expDuty;

    rst = 1'b1; run = 1'b0; clear = 1'b0; modeNext = 1'b0; dir = 1'b0;
    rstB = 1'b1; runB = 1'b0; clearB = 1'b0; modeNextB = 1'b0; dirB = 1'b0;
    repeat (3) stepClock();
    checkOutput("reset_led", led, 8'h00);
    checkOutput("reset_mode", mode, 2'd0);
    checkOutput("reset_tick", tick, 1'b0);
    rst = 1'b0;

    // Binary up count: a tick every 4 cycles, led trailing by one cycle.
    ticks = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (tick) begin
        ticks++;
        checkOutput("tick_cycle", c, ticks * 4);
      end
      if (c > 4 && (c % 4) == 1) checkOutput("bin_led", led, c / 4);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bin_ticks", ticks, 10);
    checkOutput("bin_led_final", led, 8'h0A);

    // Binary down count from reset, then freeze.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    dir = 1'b1;
    waitTicks(1);
    checkOutput("down_wrap", led, 8'hFF);
    waitTicks(2);
    checkOutput("down_fd", led, 8'hFD);
    idleTicks = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (tick) idleTicks++;
    end
    checkOutput("hold_led", led, 8'hFD);
    checkOutput("hold_ticks", idleTicks, 0);

    // Gray mode.
    dir = 1'b0;
    pulseMode();
    checkOutput("gray_mode", mode, 2'd1);
    waitTicks(5);
    checkOutput("gray_led", led, 8'h07);

    // Scan mode bounces at both ends.
    pulseMode();
    checkOutput("scan_mode", mode, 2'd2);
    checkOutput("scan_start", led, 8'h01);
    for (int i = 0; i < 16; i++) begin
      waitTicks(1);
      checkOutput($sformatf("scan_%0d", i), led, scanExp[i]);
    end
    waitTicks(1);
    checkOutput("scan_pos3", led, 8'h08);

    // Clear landing on a step suppresses it and restarts the scan.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("clear_no_tick", tick, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_led", led, 8'h01);
    waitTicks(1);
    checkOutput("clear_resume1", led, 8'h02);
    waitTicks(1);
    checkOutput("clear_resume2", led, 8'h04);

    // Breathe mode on the second instance: measure duty over 16 psc cycles per step.
    rstB = 1'b0;
    repeat (3) pulseModeB();
    checkOutput("breathe_mode", modeB, 2'd3);
    checkOutput("breathe_dark", ledB, 8'h00);
    runB = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      seenB = 0;
      for (int c = 0; c < 40 && seenB == 0; c++) begin
        stepClock();
        if (tickB) seenB = 1;
      end
      checkOutput("breathe_tick", seenB, 1);
      lit = 0;
      for (int c = 0; c < 16; c++) begin
        stepClock();
        if (ledB == 8'hFF) lit++;
      end
      expDuty = (k <= 15) ? k : (k <= 30) ? 30 - k : k - 30;
      checkOutput($sformatf("duty_%0d", k), lit, expDuty);
    end
    runB = 1'b0;
    pulseModeB();
    checkOutput("wrap_mode", modeB, 2'd0);
    checkOutput("wrap_led", ledB, 8'h00);

    // Asynchronous reset in the middle of a count.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    dir = 1'b0;
    waitTicks(90);
    checkOutput("count_5a", led, 8'h5A);
    ticks = 0;
    for (int c = 0; c < 8 && ticks == 0; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (tick) ticks = 1;
    end
    checkOutput("pre_rst_tick", tick, 1'b1);
    checkOutput("pre_rst_led", led, 8'h5A);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_led", led, 8'h00);
    checkOutput("async_tick", tick, 1'b0);
    checkOutput("async_mode", mode, 2'd0);
    #1 rst = 1'b0;
    waitTicks(1);
    checkOutput("restart_led", led, 8'h01);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED display engine, the successor to the board's fixed binary blinker. It generates WIDTH-bit LED patterns in four modes: binary count, Gray count, bounce scan and PWM breathe. Patterns advance on a programmable prescaler tick. It sits between the button debouncers and the board LED pins; buttons arrive already debounced as clean levels.

Parameters:
WIDTH, 8, number of LEDs driven (legal range 2..32)
PRESCALE, 22, prescaler width; the pattern steps every 2^PRESCALE enabled cycles (must be > PWM_BITS)
PWM_BITS, 4, breathe-mode duty resolution; 2^PWM_BITS brightness levels

Ports:
clk_25mhz  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
run  input  1  level; 1 lets the prescaler advance, 0 freezes the pattern
clear  input  1  level, synchronous; while 1, holds the pattern state and prescaler at zero
mode_next  input  1  debounced level; each rising edge advances the mode
dir  input  1  count direction for modes 0/1; 0 = up, 1 = down
led  output  WIDTH  registered LED drive, 1 = lit
mode  output  2  current mode: 0 BINARY, 1 GRAY, 2 SCAN, 3 BREATHE
tick  output  1  one-cycle pulse, registered, asserted the cycle after each pattern step

Behaviour:
- Reset (async, rst=1) forces these values immediately and holds them while asserted:
  - psc=0, cnt=0, pos=0, scan_up=1, duty=0, duty_up=1
  - mode=0, mode_next_q=0, led=0, tick=0
- Prescaler psc (PRESCALE bits):
  - psc+1 per cycle when run=1, wraps at all-ones; holds when run=0.
  - step = run & (psc == all-ones) & ~clear.
  - tick <= step.
- Mode edge detect:
  - mode_next_q <= mode_next; mode_edge = mode_next & ~mode_next_q.
  - On mode_edge: mode <= mode+1 (3 wraps to 0), and psc, cnt, pos, duty are zeroed, scan_up=1, duty_up=1.
- Priority on each edge:
  - clear (zero psc/cnt/pos/duty, scan_up=duty_up=1) together with mode_edge is applied as well.
  - Otherwise step applies.
  - A step coinciding with mode_edge is discarded.
- BINARY (0): on step, cnt <= cnt+1 (dir=0) or cnt-1 (dir=1), modulo 2^WIDTH. Wrap all-ones->0 and 0->all-ones are silent. led <= cnt.
- GRAY (1): same cnt update as BINARY; led <= cnt ^ (cnt >> 1).
- SCAN (2): led <= one-hot at bit pos; dir is ignored. On step:
  - if scan_up, pos+1; at pos=WIDTH-1, scan_up<=0 and pos<=WIDTH-2.
  - else pos-1; at pos=0, scan_up<=1 and pos<=1.
  - Sequence for WIDTH=4: 0,1,2,3,2,1,0,1...
- BREATHE (3): duty (PWM_BITS) ramps on step:
  - up 0..2^PWM_BITS-1, then down to 0, then up; endpoints are not repeated.
  - led <= all ones when psc[PWM_BITS-1:0] < duty, else all zeros.
  - duty=0 gives fully dark. When run=0, psc freezes and led holds its last value.
- Latency: led reflects the state register one cycle later; the first step after reset occurs at cycle 2^PRESCALE with run held high.
- cnt is shared by modes 0/1. pos, duty and their direction flags are kept independently, but all are zeroed on any mode change.
- Reset mid-operation: outputs zero asynchronously. The first rising edge after deassert behaves as from the reset state.

Test Plan:
- PRESCALE=2, WIDTH=8, mode 0, dir=0, run=1 for 40 cycles -> tick every 4 cycles; led after the tick sequence is 01,02,03...; 10 ticks give led=0x0A.
- Mode 0, dir=1 from reset, one step -> led=0xFF; two more steps -> 0xFD. Then run=0 for 20 cycles -> led holds 0xFD and no tick.
- Pulse mode_next once, run=1 to cnt=5 -> mode=1, led=0x07 (Gray of 5). Pulse mode_next again -> mode=2, led walks 01,02,...,80,40,20, reversing at both ends.
- In SCAN at pos=3, raise clear coincident with a step -> led returns to 0x01, no tick that cycle; on release, scanning resumes upward.
- BREATHE with PRESCALE=5, PWM_BITS=4: duty ramps 0..15..0; for duty=4, led is all ones for 4 of every 16 psc-low-nibble cycles. Toggle mode_next -> mode wraps to 0, led=0x00.
- Assert rst asynchronously mid-count (led=0x5A) -> led=0, mode=0, tick=0 before the next clock; after release, the count restarts from 0.
